// File: rtl/memory_stage_access_if.sv
// Bundle between the memory stage, data-memory ports A/B and the memory/writeback register.
// misaligned_fault exists only when VEC_ALIGN_CHECK_EN is defined.
interface memory_stage_access_if #(
   parameter int ADDR_W = 16,
   parameter int VEC_W  = 128,
   parameter int BEAT_W = 32
);
   logic              valid_memory;
   logic              write_memory_enable_a_memory;
   logic              write_memory_enable_b_memory;
   logic [1:0]        select_writeback_data_mux_memory;
   logic [1:0]        select_writeback_vector_data_mux_memory;
   logic [ADDR_W-1:0] srcA_memory;
   logic [15:0]       srcB_memory;
   logic [VEC_W-1:0]  vector_srcB_memory;
   logic [ADDR_W-1:0] mem_a_addr;
   logic [7:0]        mem_a_wdata;
   logic              mem_a_we;
   logic [7:0]        mem_a_rdata;
   logic [ADDR_W-1:0] mem_b_addr;
   logic [BEAT_W-1:0] mem_b_wdata;
   logic              mem_b_we;
   logic [BEAT_W-1:0] mem_b_rdata;
   logic [7:0]        scalar_read_data;
   logic [VEC_W-1:0]  vector_read_data;
   logic              stall_memory;
   logic              mem_done;
`ifdef VEC_ALIGN_CHECK_EN
   logic              misaligned_fault;
`endif

   modport slave (
      input  valid_memory, write_memory_enable_a_memory, write_memory_enable_b_memory,
      input  select_writeback_data_mux_memory, select_writeback_vector_data_mux_memory,
      input  srcA_memory, srcB_memory, vector_srcB_memory, mem_a_rdata, mem_b_rdata,
      output mem_a_addr, mem_a_wdata, mem_a_we, mem_b_addr, mem_b_wdata, mem_b_we,
      output scalar_read_data, vector_read_data, stall_memory, mem_done
`ifdef VEC_ALIGN_CHECK_EN
      , output misaligned_fault
`endif
   );

   modport master (
      output valid_memory, write_memory_enable_a_memory, write_memory_enable_b_memory,
      output select_writeback_data_mux_memory, select_writeback_vector_data_mux_memory,
      output srcA_memory, srcB_memory, vector_srcB_memory, mem_a_rdata, mem_b_rdata,
      input  mem_a_addr, mem_a_wdata, mem_a_we, mem_b_addr, mem_b_wdata, mem_b_we,
      input  scalar_read_data, vector_read_data, stall_memory, mem_done
`ifdef VEC_ALIGN_CHECK_EN
      , input misaligned_fault
`endif
   );
endinterface

// File: rtl/memory_stage_access.sv
// Memory-stage access engine: scalar byte port A, multi-beat vector port B, pipeline stall/done.
// Optional VEC_ALIGN_CHECK_EN rejects vector accesses whose base is not beat-group aligned.
module memory_stage_access #(
   parameter int ADDR_W = 16,
   parameter int VEC_W  = 128,
   parameter int BEAT_W = 32
) (
   input logic                  clk,
   input logic                  reset,
   memory_stage_access_if.slave bus
);
   localparam int BEATS = VEC_W / BEAT_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [2:0] {IDLE, VST, VLD, VDRAIN, SWAIT} state_e;
   typedef logic [BEATS-1:0][BEAT_W-1:0] beats_t;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] base_q, base_d;
   beats_t            vec_q, vec_d;
   beats_t            cap_q, cap_d;
   beats_t            vout_q, vout_d;
   beats_t            vec_in, drain_vec;
   logic [7:0]        shold_q, shold_d;
   logic              sret_q, sret_d;

   logic sst_req, sld_req, vst_req, vld_req, lost_s, lost_v;
   logic vec_pend, scal_pend, busy;
   logic unused_srcb_hi;

   assign unused_srcb_hi = ^bus.srcB_memory[15:8];
   assign vec_in         = bus.vector_srcB_memory;

   // Stores win over loads on the same port; a lost load reports zero.
   assign sst_req = bus.write_memory_enable_a_memory;
   assign lost_s  = sst_req && (bus.select_writeback_data_mux_memory == 2'b01);
   assign sld_req = (bus.select_writeback_data_mux_memory == 2'b01) && !sst_req;
   assign lost_v  = bus.write_memory_enable_b_memory &&
                    (bus.select_writeback_vector_data_mux_memory == 2'b01);
`ifdef VEC_ALIGN_CHECK_EN
   logic misaligned;
   assign misaligned = (bus.write_memory_enable_b_memory ||
                        (bus.select_writeback_vector_data_mux_memory == 2'b01)) &&
                       (bus.srcA_memory[CNT_W-1:0] != '0);
`else
   logic misaligned;
   assign misaligned = 1'b0;
`endif
   assign vst_req = bus.write_memory_enable_b_memory && !misaligned;
   assign vld_req = (bus.select_writeback_vector_data_mux_memory == 2'b01) &&
                    !bus.write_memory_enable_b_memory && !misaligned;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      state_d   = state_q;
      cnt_d     = cnt_q;
      base_d    = base_q;
      vec_d     = vec_q;
      cap_d     = cap_q;
      vout_d    = vout_q;
      shold_d   = shold_q;
      sret_d    = 1'b0;
      vec_pend  = 1'b0;
      scal_pend = 1'b0;
      busy      = 1'b0;
      drain_vec = cap_q;
      bus.mem_a_addr       = '0;
      bus.mem_a_wdata      = '0;
      bus.mem_a_we         = 1'b0;
      bus.mem_b_addr       = '0;
      bus.mem_b_wdata      = '0;
      bus.mem_b_we         = 1'b0;
      bus.scalar_read_data = '0;
      bus.vector_read_data = '0;
      bus.stall_memory     = 1'b0;
      bus.mem_done         = 1'b0;
`ifdef VEC_ALIGN_CHECK_EN
      bus.misaligned_fault = 1'b0;
`endif
      if (!reset) begin
         bus.scalar_read_data = shold_q;
         bus.vector_read_data = vout_q;
         unique case (state_q)
            IDLE: if (bus.valid_memory) begin
               base_d = bus.srcA_memory;
               vec_d  = vec_in;
               cnt_d  = CNT_W'(1);
               sret_d = sld_req;
               if (sst_req || sld_req) bus.mem_a_addr = bus.srcA_memory;
               bus.mem_a_we    = sst_req;
               bus.mem_a_wdata = sst_req ? bus.srcB_memory[7:0] : 8'h00;
               if (lost_s) shold_d = '0;
               if (vst_req || vld_req) bus.mem_b_addr = bus.srcA_memory;
               bus.mem_b_we    = vst_req;
               bus.mem_b_wdata = vst_req ? vec_in[0] : '0;
               if (lost_v || misaligned) vout_d = '0;
               if (misaligned) bus.vector_read_data = '0;
`ifdef VEC_ALIGN_CHECK_EN
               bus.misaligned_fault = misaligned;
`endif
               vec_pend  = vld_req || (vst_req && (BEATS > 1));
               scal_pend = sld_req;
               if (vec_pend)     state_d = vst_req ? VST : VLD;
               else if (sld_req) state_d = SWAIT;
            end
            VST: begin
               bus.mem_b_addr  = base_q + ADDR_W'(cnt_q);
               bus.mem_b_we    = 1'b1;
               bus.mem_b_wdata = vec_q[cnt_q];
               cnt_d    = cnt_q + CNT_W'(1);
               vec_pend = (cnt_q != LAST_BEAT);
               if (!vec_pend) state_d = IDLE;
            end
            VLD: begin
               bus.mem_b_addr = base_q + ADDR_W'(cnt_q);
               cap_d[cnt_q - CNT_W'(1)] = bus.mem_b_rdata;
               cnt_d    = cnt_q + CNT_W'(1);
               vec_pend = 1'b1;
               if (cnt_q == LAST_BEAT) state_d = VDRAIN;
            end
            VDRAIN: begin
               // Top beat comes straight from the port in the completion cycle.
               drain_vec[BEATS-1]   = bus.mem_b_rdata;
               bus.vector_read_data = drain_vec;
               vout_d  = drain_vec;
               state_d = IDLE;
            end
            SWAIT:   state_d = IDLE;
            default: state_d = IDLE;
         endcase
         if (sret_q) begin
            bus.scalar_read_data = bus.mem_a_rdata;
            shold_d              = bus.mem_a_rdata;
         end
         busy             = (state_q != IDLE) || bus.valid_memory;
         bus.mem_done     = busy && !vec_pend && !scal_pend;
         bus.stall_memory = busy && !bus.mem_done;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
         vec_q   <= '0;
         cap_q   <= '0;
         vout_q  <= '0;
         shold_q <= '0;
         sret_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         vec_q   <= vec_d;
         cap_q   <= cap_d;
         vout_q  <= vout_d;
         shold_q <= shold_d;
         sret_q  <= sret_d;
      end
   end
endmodule

// File: tb/tb_memory_stage_access.sv
// Self-checking bench for memory_stage_access: directed plan cases plus random instructions
// checked against an instruction-level reference model of memory and result registers.
module tb_memory_stage_access;
   localparam int ADDR_W = 16;
   localparam int VEC_W  = 128;
   localparam int BEAT_W = 32;
   localparam int BEATS  = VEC_W / BEAT_W;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   int   b_writes = 0;

   memory_stage_access_if #(.ADDR_W(ADDR_W), .VEC_W(VEC_W), .BEAT_W(BEAT_W)) bus ();
   memory_stage_access #(.ADDR_W(ADDR_W), .VEC_W(VEC_W), .BEAT_W(BEAT_W)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Memory contents: a fixed hash per address until written.
   logic [7:0]  mem_a [0:65535];
   logic [31:0] mem_b [0:65535];
   bit          wr_a  [0:65535];
   bit          wr_b  [0:65535];
   logic [7:0]  ref_a [0:65535];
   logic [31:0] ref_b [0:65535];
   bit          rwr_a [0:65535];
   bit          rwr_b [0:65535];
   logic [7:0]   last_srd;
   logic [127:0] last_vrd;

   function automatic logic [7:0] init_a(input logic [15:0] ad);
      return ad[7:0] ^ ad[15:8] ^ 8'h5A;
   endfunction
   function automatic logic [31:0] init_b(input logic [15:0] ad);
      return {ad, ~ad} ^ 32'h9E3779B9;
   endfunction
   function automatic logic [7:0] rd_a(input logic [15:0] ad);
      return wr_a[ad] ? mem_a[ad] : init_a(ad);
   endfunction
   function automatic logic [31:0] rd_b(input logic [15:0] ad);
      return wr_b[ad] ? mem_b[ad] : init_b(ad);
   endfunction
   function automatic logic [7:0] ref_rd_a(input logic [15:0] ad);
      return rwr_a[ad] ? ref_a[ad] : init_a(ad);
   endfunction
   function automatic logic [31:0] ref_rd_b(input logic [15:0] ad);
      return rwr_b[ad] ? ref_b[ad] : init_b(ad);
   endfunction

   always @(posedge clk) begin
      if (bus.mem_a_we === 1'b1) begin
         mem_a[bus.mem_a_addr] <= bus.mem_a_wdata;
         wr_a[bus.mem_a_addr]  <= 1'b1;
      end
      if (bus.mem_b_we === 1'b1) begin
         mem_b[bus.mem_b_addr] <= bus.mem_b_wdata;
         wr_b[bus.mem_b_addr]  <= 1'b1;
         b_writes              <= b_writes + 1;
      end
      bus.mem_a_rdata <= rd_a(bus.mem_a_addr);
      bus.mem_b_rdata <= rd_b(bus.mem_b_addr);
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.valid_memory                            = 1'b0;
      bus.write_memory_enable_a_memory            = 1'b0;
      bus.write_memory_enable_b_memory            = 1'b0;
      bus.select_writeback_data_mux_memory        = 2'b00;
      bus.select_writeback_vector_data_mux_memory = 2'b00;
      bus.srcA_memory                             = '0;
      bus.srcB_memory                             = '0;
      bus.vector_srcB_memory                      = '0;
   endtask

   // One instruction: launch, watch until mem_done (bounded), then compare against the model.
   task automatic run_instr(input logic we_a, input logic [1:0] sel_s, input logic we_b,
                            input logic [1:0] sel_v, input logic [15:0] a,
                            input logic [15:0] b, input logic [127:0] v);
      bit sst, sld, vst, vld, mis, lost_s, lost_v;
      int exp_cycles, cyc, done_cyc, stalls, a_we_cnt, b_we_cnt;
      logic [7:0]   exp_byte, srd_done;
      logic [127:0] exp_vec, vrd_done;
      logic         fault0;
      sst    = we_a;
      lost_s = we_a && (sel_s == 2'b01);
      sld    = (sel_s == 2'b01) && !we_a;
      mis    = 1'b0;
`ifdef VEC_ALIGN_CHECK_EN
      mis = (we_b || (sel_v == 2'b01)) && ((a % BEATS) != 0);
`endif
      vst    = we_b && !mis;
      vld    = (sel_v == 2'b01) && !we_b && !mis;
      lost_v = we_b && (sel_v == 2'b01);
      exp_cycles = 1;
      if (sld) exp_cycles = 2;
      if (vst && BEATS > exp_cycles) exp_cycles = BEATS;
      if (vld) exp_cycles = BEATS + 1;
      exp_byte = ref_rd_a(a);
      for (int i = 0; i < BEATS; i++) exp_vec[32*i +: 32] = ref_rd_b(16'(a + i));

      @(posedge clk); #1;
      bus.valid_memory                            = 1'b1;
      bus.write_memory_enable_a_memory            = we_a;
      bus.write_memory_enable_b_memory            = we_b;
      bus.select_writeback_data_mux_memory        = sel_s;
      bus.select_writeback_vector_data_mux_memory = sel_v;
      bus.srcA_memory                             = a;
      bus.srcB_memory                             = b;
      bus.vector_srcB_memory                      = v;
      cyc = 0; done_cyc = -1; stalls = 0; a_we_cnt = 0; b_we_cnt = 0;
      srd_done = 'x; vrd_done = 'x; fault0 = 1'b0;
      while (cyc < 16 && done_cyc < 0) begin
         @(negedge clk);
         if (bus.mem_a_we === 1'b1) a_we_cnt++;
         if (bus.mem_b_we === 1'b1) b_we_cnt++;
         if (bus.stall_memory === 1'b1) stalls++;
`ifdef VEC_ALIGN_CHECK_EN
         if (cyc == 0) fault0 = bus.misaligned_fault;
`endif
         if (bus.mem_done === 1'b1) begin
            done_cyc = cyc;
            srd_done = bus.scalar_read_data;
            vrd_done = bus.vector_read_data;
         end
         @(posedge clk); #1;
         cyc++;
         // Upstream values change freely; the engine must rely on its launch-time copies.
         bus.srcA_memory        = 16'($urandom);
         bus.srcB_memory        = 16'($urandom);
         bus.vector_srcB_memory = {$urandom, $urandom, $urandom, $urandom};
      end
      clear_inputs();

      check("done_cycle", 128'(done_cyc), 128'(exp_cycles - 1));
      check("stall_cycles", 128'(stalls), 128'(exp_cycles - 1));
      check("a_we_count", 128'(a_we_cnt), 128'(sst ? 1 : 0));
      check("b_we_count", 128'(b_we_cnt), 128'(vst ? BEATS : 0));
      if (sld) check("scalar_load", srd_done, exp_byte);
      if (vld) check("vector_load", vrd_done, exp_vec);
`ifdef VEC_ALIGN_CHECK_EN
      check("misaligned_fault", fault0, mis);
`endif

      if (sst) begin
         ref_a[a] = b[7:0];
         rwr_a[a] = 1'b1;
      end
      if (vst) for (int i = 0; i < BEATS; i++) begin
         ref_b[16'(a + i)] = v[32*i +: 32];
         rwr_b[16'(a + i)] = 1'b1;
      end
      if (sld) last_srd = exp_byte;
      if (lost_s) last_srd = 8'h00;
      if (vld) last_vrd = exp_vec;
      if (lost_v || mis) last_vrd = '0;

      @(negedge clk);
      check("idle_stall", bus.stall_memory, 1'b0);
      check("idle_done", bus.mem_done, 1'b0);
      check("scalar_hold", bus.scalar_read_data, last_srd);
      check("vector_hold", bus.vector_read_data, last_vrd);
      if (sst) check("mem_a_contents", rd_a(a), ref_rd_a(a));
      if (vst) for (int i = 0; i < BEATS; i++)
         check("mem_b_contents", rd_b(16'(a + i)), ref_rd_b(16'(a + i)));
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int wb_start, wb_reset;
      logic [15:0]  ra;
      logic [127:0] rv;
      clear_inputs();
      reset    = 1'b1;
      last_srd = 8'h00;
      last_vrd = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_stall", bus.stall_memory, 1'b0);
      check("reset_done", bus.mem_done, 1'b0);
      check("reset_a_we", bus.mem_a_we, 1'b0);
      check("reset_b_we", bus.mem_b_we, 1'b0);
      check("reset_b_addr", bus.mem_b_addr, 16'h0000);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_reset_srd", bus.scalar_read_data, 8'h00);
      check("post_reset_vrd", bus.vector_read_data, 128'h0);
      check("post_reset_stall", bus.stall_memory, 1'b0);

      // Directed plan cases.
      run_instr(1'b1, 2'b00, 1'b0, 2'b00, 16'h0010, 16'h00A5, '0);
      run_instr(1'b1, 2'b00, 1'b0, 2'b00, 16'h0020, 16'h003C, '0);
      run_instr(1'b0, 2'b01, 1'b0, 2'b00, 16'h0020, 16'h0000, '0);
      run_instr(1'b0, 2'b00, 1'b1, 2'b00, 16'h0100, 16'h0000,
                128'h44444444_33333333_22222222_11111111);
      run_instr(1'b0, 2'b00, 1'b0, 2'b01, 16'hFFFE, 16'h0000, '0);
      run_instr(1'b0, 2'b00, 1'b0, 2'b01, 16'h0100, 16'h0000, '0);
      run_instr(1'b0, 2'b00, 1'b0, 2'b00, 16'h1234, 16'h0000, '0);
      run_instr(1'b0, 2'b01, 1'b0, 2'b01, 16'h0100, 16'h0000, '0);
      run_instr(1'b1, 2'b01, 1'b1, 2'b01, 16'h0030, 16'h0077,
                128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
`ifdef VEC_ALIGN_CHECK_EN
      run_instr(1'b0, 2'b00, 1'b1, 2'b00, 16'h0102, 16'h0000, {4{32'h5555AAAA}});
      run_instr(1'b0, 2'b01, 1'b0, 2'b01, 16'h0103, 16'h0000, '0);
`endif

      // Reset in the middle of a vector store: beats 0 and 1 land, nothing after.
      wb_start = b_writes;
      rv = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
      @(posedge clk); #1;
      bus.valid_memory                 = 1'b1;
      bus.write_memory_enable_b_memory = 1'b1;
      bus.srcA_memory                  = 16'h0200;
      bus.vector_srcB_memory           = rv;
      @(posedge clk); #1;
      clear_inputs();
      @(posedge clk); #1;
      reset    = 1'b1;
      wb_reset = b_writes;
      @(negedge clk);
      check("reset_burst_b_we", bus.mem_b_we, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_stall", bus.stall_memory, 1'b0);
      check("abort_b_we", bus.mem_b_we, 1'b0);
      @(posedge clk); #1;
      check("abort_no_more_writes", 128'(b_writes - wb_reset), 128'(0));
      check("abort_writes_before", 128'(wb_reset - wb_start), 128'(2));
      for (int i = 0; i < 2; i++) begin
         ref_b[16'(16'h0200 + i)] = rv[32*i +: 32];
         rwr_b[16'(16'h0200 + i)] = 1'b1;
      end
      for (int i = 0; i < BEATS; i++)
         check("abort_mem_b", rd_b(16'(16'h0200 + i)), ref_rd_b(16'(16'h0200 + i)));
      last_srd = 8'h00;
      last_vrd = '0;

      // Random instruction mix against the reference model.
      for (int n = 0; n < 60; n++) begin
         if ($urandom % 4 == 0)      ra = 16'(16'hFFFC + ($urandom % 4));
         else if ($urandom % 2 == 0) ra = 16'($urandom_range(0, 31));
         else                        ra = 16'($urandom);
         run_instr(($urandom % 3) == 0,
                   ($urandom % 2) ? 2'b01 : 2'($urandom % 4),
                   ($urandom % 3) == 0,
                   ($urandom % 2) ? 2'b01 : 2'($urandom % 4),
                   ra, 16'($urandom),
                   {$urandom, $urandom, $urandom, $urandom});
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/memory_stage_access.md
Name: memory_stage_access

Overview:
- Memory-stage access engine, directly downstream of the execute/memory pipeline register.
- Consumes memory-stage controls, address and store data. Drives the scalar byte port (A) and the vector beat port (B) of data memory.
- Vector transfers are sequenced as multi-beat bursts. Stalls the pipeline until every access completes.
- Presents scalar and vector load data to the memory/writeback register.

Parameters:
ADDR_W, 16, address width of both memory ports
VEC_W, 128, vector register width
BEAT_W, 32, port-B data width; BEATS = VEC_W/BEAT_W (default 4), must be a power of 2

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
valid_memory  in  1  instruction present in memory stage
write_memory_enable_a_memory  in  1  scalar byte store
write_memory_enable_b_memory  in  1  vector store
select_writeback_data_mux_memory  in  2  2'b01 = scalar load
select_writeback_vector_data_mux_memory  in  2  2'b01 = vector load
srcA_memory  in  16  base address (byte address for A, beat address for B)
srcB_memory  in  16  scalar store data, bits [7:0] used
vector_srcB_memory  in  128  vector store data
mem_a_addr  out  16  port A address
mem_a_wdata  out  8  port A write data
mem_a_we  out  1  port A write strobe
mem_a_rdata  in  8  port A read data, 1-cycle latency
mem_b_addr  out  16  port B address
mem_b_wdata  out  32  port B write data
mem_b_we  out  1  port B write strobe
mem_b_rdata  in  32  port B read data, 1-cycle latency
scalar_read_data  out  8  scalar load result
vector_read_data  out  128  vector load result
stall_memory  out  1  freeze upstream stages while 1
mem_done  out  1  one-cycle pulse when the instruction completes

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high, on reset.
- Reset values: FSM = IDLE, beat counter = 0. All outputs 0: addresses, wdata, we, read data, stall_memory, mem_done. Capture registers = 0.
- Reset mid-burst: abort to IDLE on that edge, no further writes. Beats already written stay written.
- Launch: occurs in IDLE with valid_memory=1. That cycle latches address, scalar data, vector data and operation flags into internal registers. The remainder of the operation uses only the latched values.
- Priority: store wins over load on the same port; the losing load returns 0. Scalar and vector operations run concurrently on their own ports.
- Scalar store: launch cycle drives mem_a_we=1, mem_a_addr=srcA, mem_a_wdata=srcB[7:0]. Takes 1 cycle and alone causes no stall.
- Scalar load: launch cycle issues the address. Data returns the next cycle and is captured into a hold register. scalar_read_data = live mem_a_rdata in the return cycle, hold register afterwards.
- FSM states: IDLE, VST (vector store), VLD (vector load issue), VDRAIN (last load beat return), SWAIT (scalar load return only).
- Vector store: beat i drives mem_b_addr = base+i and mem_b_wdata = vec[32i+31:32i], i = 0..BEATS-1, one beat per cycle, starting in the launch cycle. Takes BEATS cycles. stall_memory=1 for the first BEATS-1 cycles.
- Vector load: beat i address is issued in cycle i. Data for beat i returns in cycle i+1 and is placed in bits [32i+31:32i]. Takes BEATS+1 cycles.
  - stall_memory=1 for cycles 0..BEATS-1.
  - In the final cycle, vector_read_data = {live mem_b_rdata, captured lower beats}. It then holds until the next vector load completes.
- Beat address arithmetic: base+i is computed modulo 2^16; 16'hFFFF + 1 wraps to 16'h0000.
- Completion: stall_memory deasserts in the cycle the last outstanding access (scalar or vector) completes. mem_done=1 in that same cycle.
- Back-to-back: a new launch may occur in the cycle after mem_done. With no memory operation and valid_memory=1, mem_done pulses with no stall.
- Stall discipline: stall_memory never asserts for a scalar-only store.

Optional Feature:
- Macro: VEC_ALIGN_CHECK_EN.
- Defined: adds output misaligned_fault (1 bit).
  - A vector access with base[log2(BEATS)-1:0] != 0 performs no port-B access (mem_b_we stays 0).
  - It completes in the launch cycle with mem_done=1 and misaligned_fault=1 for that cycle. vector_read_data is forced to 0.
  - Any scalar access in the same instruction proceeds normally.
- Undefined: no port, no check. Unaligned bursts execute with wrap-around addressing.

Test Plan:
- Scalar store: srcA=16'h0010, srcB=16'h00A5 -> one cycle of mem_a_we=1 with addr 0x0010 and data 0xA5; stall_memory stays 0; mem_done=1.
- Scalar load: addr 0x0020, memory returns 0x3C -> stall for 1 cycle; scalar_read_data=0x3C when mem_done=1.
- Vector store: base 0x0100, vector 128'h44444444_33333333_22222222_11111111 -> 4 writes to 0x100..0x103 with data 0x11111111..0x44444444; stall_memory high for 3 cycles.
- Vector load with wrap: base 0xFFFE -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; returned beats assemble in order; 5 cycles; mem_done on cycle 4.
- Reset mid-burst: reset asserted after the beat-1 store -> next cycle IDLE, stall_memory=0, no further mem_b_we.
- Concurrent and priority: scalar load plus vector load in one instruction -> both results correct, single mem_done. Store+load on the same port -> store only, load result 0. With VEC_ALIGN_CHECK_EN and base 0x0102 -> misaligned_fault=1, no port-B writes.
